// File: rtl/affine_sched_pkg.sv
// Shared constants, id-width helper and tag type for the affine scheduler.
// Imported by affine_pipe2 and affine_rr_scheduler.
package affine_sched_pkg;

  localparam int DEF_W  = 16;
  localparam int DEF_N  = 4;
  localparam int DEF_K1 = 3;
  localparam int DEF_B1 = 5;
  localparam int DEF_K2 = 2;
  localparam int DEF_B2 = 7;

  // Widest id needed for the largest supported N (16).
  localparam int MAX_ID_W = 4;

  // Requester id width; never below 1 so N=1 still has a legal vector.
  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [MAX_ID_W-1:0]      id;
    logic signed [DEF_W-1:0]  x;
  } affine_tag_t;

endpackage

// File: rtl/affine_pipe2.sv
// Two-stage affine datapath: S1 p = x*K1+B1, S2 y = p*K2+B2, wrap mod 2^W.
// Ports: clk, rst, in_valid/in_id/in_x -> out_valid/out_id/out_y (2 cycles later).
module affine_pipe2
  import affine_sched_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int ID_W = 2,
  parameter logic signed [W-1:0] K1 = W'(DEF_K1),
  parameter logic signed [W-1:0] B1 = W'(DEF_B1),
  parameter logic signed [W-1:0] K2 = W'(DEF_K2),
  parameter logic signed [W-1:0] B2 = W'(DEF_B2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [ID_W-1:0]     in_id,
  input  logic signed [W-1:0] in_x,
  output logic                out_valid,
  output logic [ID_W-1:0]     out_id,
  output logic signed [W-1:0] out_y
);

  logic                s1_v;
  logic [ID_W-1:0]     s1_id;
  logic signed [W-1:0] s1_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_v      <= in_valid;
      out_valid <= s1_v;
    end
  end

  // Data and id need no reset; only the valids qualify them.
  always_ff @(posedge clk) begin
    s1_id  <= in_id;
    s1_p   <= in_x * K1 + B1;
    out_id <= s1_id;
    out_y  <= s1_p * K2 + B2;
  end

endmodule

// File: rtl/affine_rr_scheduler.sv
// Round-robin sharing of one affine_pipe2 among N valid/ready requesters.
// Ports: clk, rst, req_valid/req_x/req_ready, resp_valid/resp_y/resp_ready,
// stat_grants (only with AFFINE_SCHED_STATS_EN: saturating per-requester grant counts).
module affine_rr_scheduler
  import affine_sched_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N,
  parameter logic signed [W-1:0] K1 = W'(DEF_K1),
  parameter logic signed [W-1:0] B1 = W'(DEF_B1),
  parameter logic signed [W-1:0] K2 = W'(DEF_K2),
  parameter logic signed [W-1:0] B2 = W'(DEF_B2)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_x,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   resp_valid,
  output logic [N*W-1:0] resp_y,
  input  logic [N-1:0]   resp_ready
`ifdef AFFINE_SCHED_STATS_EN
  ,
  output logic [N*16-1:0] stat_grants
`endif
);

  localparam int ID_W = id_w(N);

  logic [N-1:0]    busy;
  logic [N-1:0]    elig;
  logic [N-1:0]    grant;
  logic [N-1:0]    slot_v;
  logic [N-1:0]    hit;
  logic [N-1:0]    consume;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gid;
  logic [ID_W-1:0] nxt_ptr;
  logic            found;
  logic [W-1:0]    slot_y [N];

  logic                p_v;
  logic [ID_W-1:0]     p_id;
  logic signed [W-1:0] p_y;

  assign elig = req_valid & ~busy;

  // Cyclic first-eligible search starting at rr_ptr.
  always_comb begin
    found = 1'b0;
    gid   = '0;
    grant = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && elig[(int'(rr_ptr) + k) % N]) begin
        found = 1'b1;
        gid   = ID_W'((int'(rr_ptr) + k) % N);
      end
    end
    if (found) grant[gid] = 1'b1;
  end

  assign req_ready = grant;
  assign nxt_ptr   = (int'(gid) == N - 1) ? '0 : gid + ID_W'(1);

  affine_pipe2 #(
    .W(W), .ID_W(ID_W),
    .K1(K1), .B1(B1), .K2(K2), .B2(B2)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (found),
    .in_id    (gid),
    .in_x     (req_x[int'(gid)*W +: W]),
    .out_valid(p_v),
    .out_id   (p_id),
    .out_y    (p_y)
  );

  // The S2 result is presented directly in its arrival cycle, then held
  // by the slot register until consumed. busy keeps the slot free on arrival.
  always_comb begin
    hit    = '0;
    resp_y = '0;
    for (int i = 0; i < N; i++) begin
      hit[i] = p_v && (p_id == ID_W'(i));
      resp_y[i*W +: W] = hit[i] ? p_y : slot_y[i];
    end
  end

  assign resp_valid = slot_v | hit;
  assign consume    = resp_valid & resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= '0;
      slot_v <= '0;
      rr_ptr <= '0;
      for (int i = 0; i < N; i++) slot_y[i] <= '0;
    end else begin
      if (found) rr_ptr <= nxt_ptr;
      busy   <= (busy | grant) & ~consume;
      slot_v <= (slot_v | hit) & ~consume;
      for (int i = 0; i < N; i++) begin
        if (hit[i]) slot_y[i] <= p_y;
      end
    end
  end

`ifdef AFFINE_SCHED_STATS_EN
  logic [15:0] cnt [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (grant[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) stat_grants[i*16 +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_affine_rr_scheduler.sv
// Directed self-checking bench for affine_rr_scheduler (W=16, N=4).
// Table of single-request vectors plus fairness, backpressure and reset sequences.
module tb_affine_rr_scheduler;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_x;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [N*W-1:0] resp_y;
  logic [N-1:0]   resp_ready;
`ifdef AFFINE_SCHED_STATS_EN
  logic [N*16-1:0] stat_grants;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int           id;
    logic [W-1:0] x;
    logic [W-1:0] y;
  } vec_t;

  vec_t vt [7];
  int   fair_exp [8];
  int   bp_exp [12];

  always #5 clk = ~clk;

  affine_rr_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_y     (resp_y),
    .resp_ready (resp_ready)
`ifdef AFFINE_SCHED_STATS_EN
    ,
    .stat_grants(stat_grants)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    #4;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    req_x      = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [N-1:0] oh;
    oh = N'(1) << v.id;
    req_valid = oh;
    req_x[v.id*W +: W] = v.x;
    resp_ready = '0;
    peek();
    chk($sformatf("vec%0d_ready", v.id), 32'(req_ready), 32'(oh));
    tick();
    req_valid = '0;
    peek();
    chk("vec_lat1_valid", 32'(resp_valid), 32'(0));
    tick();
    resp_ready = oh;
    peek();
    chk("vec_lat2_valid", 32'(resp_valid), 32'(oh));
    chk($sformatf("vec_y_x%0h", v.x), 32'(resp_y[v.id*W +: W]), 32'(v.y));
    tick();
    resp_ready = '0;
  endtask

  task automatic drain();
    req_valid  = '0;
    resp_ready = '1;
    repeat (4) tick();
    resp_ready = '0;
  endtask

  initial begin
    vt[0] = '{0, 16'd1,          16'd23};
    vt[1] = '{1, 16'd0,          16'd17};
    vt[2] = '{2, 16'(-2),        16'd5};
    vt[3] = '{3, 16'd20000,      16'(-11055)};
    vt[4] = '{0, 16'(-1),        16'd11};
    vt[5] = '{2, 16'd100,        16'd617};
    vt[6] = '{1, 16'h8000,       16'd17};
    fair_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
    bp_exp   = '{0, 1, 2, 3, 0, 2, 3, 0, 2, 3, 0, 1};

    do_reset();
    peek();
    chk("rst_req_ready",  32'(req_ready),  32'(0));
    chk("rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("rst_resp_y_lo",  resp_y[31:0],    32'(0));
    chk("rst_resp_y_hi",  resp_y[63:32],   32'(0));
    tick();

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // Fairness: all valid, always consuming.
    do_reset();
    for (int i = 0; i < N; i++) req_x[i*W +: W] = 16'(10 + i);
    req_valid  = '1;
    resp_ready = '1;
    for (int c = 0; c < 8; c++) begin
      peek();
      chk($sformatf("fair_c%0d", c), 32'(req_ready),
          32'(N'(1) << fair_exp[c]));
      tick();
    end
    drain();

    // Backpressure on requester 1 for 10 cycles.
    do_reset();
    for (int i = 0; i < N; i++) req_x[i*W +: W] = 16'(10 + i);
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      resp_ready = (c < 10) ? 4'b1101 : 4'b1111;
      peek();
      chk($sformatf("bp_c%0d", c), 32'(req_ready),
          32'(N'(1) << bp_exp[c]));
      if (c == 5 || c == 9) begin
        chk($sformatf("bp_slot1_v_c%0d", c), 32'(resp_valid[1]), 32'(1));
        chk($sformatf("bp_slot1_y_c%0d", c), 32'(resp_y[W +: W]), 32'd83);
      end
      tick();
    end
    drain();

    // Reset with two grants in flight.
    do_reset();
    req_x = '0;
    req_valid = 4'b0011;
    peek();
    chk("rs_grant0", 32'(req_ready), 32'(4'b0001));
    tick();
    rst = 1'b1;
    peek();
    tick();
    rst = 1'b0;
    req_valid = '0;
    resp_ready = '1;
    for (int c = 2; c < 6; c++) begin
      peek();
      chk($sformatf("rs_noresp_c%0d", c), 32'(resp_valid), 32'(0));
      tick();
    end
    resp_ready = '0;
    req_valid = '1;
    peek();
    chk("rs_first_grant", 32'(req_ready), 32'(4'b0001));
    tick();
    drain();

`ifdef AFFINE_SCHED_STATS_EN
    do_reset();
    for (int k = 0; k < 5; k++) run_vec('{2, 16'd1, 16'd23});
    peek();
    chk("stat_req2", 32'(stat_grants[2*16 +: 16]), 32'd5);
    chk("stat_req0", 32'(stat_grants[15:0]), 32'd0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
